// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: back-buffer write/commit handshake and LED drive lines of the matrix scanner.
// The brightness input exists only when LED_MATRIX_PWM_EN is defined.
interface led_matrix_scanner_if;
   logic       wr_valid;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       commit;
   logic       frame_done;
   logic [7:0] row;
   logic [7:0] d;
`ifdef LED_MATRIX_PWM_EN
   logic [3:0] brightness;
`endif
   modport master (
      input  wr_ready, frame_done, row, d,
      output wr_valid, wr_row, wr_data, commit
`ifdef LED_MATRIX_PWM_EN
      , brightness
`endif
   );
   modport slave (
      output wr_ready, frame_done, row, d,
      input  wr_valid, wr_row, wr_data, commit
`ifdef LED_MATRIX_PWM_EN
      , brightness
`endif
   );
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered 8x8 LED matrix row scanner with frame-boundary buffer swap.
// Optional LED_MATRIX_PWM_EN adds a 4-bit brightness PWM on the column data.
module led_matrix_scanner #(
   parameter int SCAN_DIV     = 27000,
   parameter int BLANK_CYCLES = 64
) (
   input logic                 clock,
   input logic                 reset_n,
   led_matrix_scanner_if.slave bus
);
   localparam int            DW   = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] BLK  = DW'(BLANK_CYCLES);
   logic [DW-1:0] r_div;
   logic [2:0]    r_row_idx;
   logic          r_front;
   logic          r_pending;
   logic          r_frame_done;
   logic [7:0]    r_buf [2][8];
   logic [7:0]    r_row;
   logic [7:0]    r_d;
   logic          w_last;
   logic          w_boundary;
   logic          w_swap;
   logic          w_active;
   logic          w_wr;
   logic [7:0]    w_pix;
   assign w_last     = r_div == LAST;
   assign w_boundary = w_last && r_row_idx == 3'd7;
   assign w_swap     = w_boundary && (r_pending || bus.commit);
   assign w_active   = r_div >= BLK;
   assign w_wr       = bus.wr_valid && !r_pending;
`ifdef LED_MATRIX_PWM_EN
   logic [3:0] r_pwm;
   logic [3:0] w_pwm;
   // PWM phase restarts at the first active cycle of every row period
   assign w_pwm = r_div == BLK ? 4'd0 : r_pwm;
   assign w_pix = w_pwm < bus.brightness ? r_buf[r_front][r_row_idx] : 8'h00;
   always_ff @(posedge clock) begin
      if (!reset_n)
         r_pwm <= '0;
      else if (w_active)
         r_pwm <= w_pwm + 4'd1;
   end
`else
   assign w_pix = r_buf[r_front][r_row_idx];
`endif
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_div        <= '0;
         r_row_idx    <= '0;
         r_front      <= 1'b0;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
         r_row        <= 8'hFF;
         r_d          <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            r_buf[0][i] <= '0;
            r_buf[1][i] <= '0;
         end
      end else begin
         r_div <= w_last ? '0 : r_div + DW'(1);
         if (w_last)
            r_row_idx <= r_row_idx + 3'd1;
         // a write on the swap cycle lands in the old back buffer, i.e. the new front
         if (w_wr)
            r_buf[~r_front][bus.wr_row] <= bus.wr_data;
         r_front      <= r_front ^ w_swap;
         r_pending    <= w_swap ? 1'b0 : r_pending | bus.commit;
         r_frame_done <= w_swap;
         r_row        <= w_active ? ~(8'h01 << r_row_idx) : 8'hFF;
         r_d          <= w_active ? w_pix : 8'h00;
      end
   end
   assign bus.wr_ready   = !r_pending;
   assign bus.frame_done = r_frame_done;
   assign bus.row        = r_row;
   assign bus.d          = r_d;
endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Downstream display stage of the board top. Consumes 8x8 pixel frames written by the CPU core and time-multiplexes them onto the shared 8-row LED matrix.
- Drives `row[7:0]` (active-low row select) and `d[7:0]` (active-high column data).
- Double-buffered: the core writes a back buffer while the front buffer is scanned; the buffers swap only at a frame boundary, so no tearing is visible.

Parameters:
- `SCAN_DIV`, 27000: clock cycles per row period (1 kHz row rate at 27 MHz). Must be >= 2.
- `BLANK_CYCLES`, 64: cycles at the start of each row period with all rows off (anti-ghosting). Must be < `SCAN_DIV`.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `wr_valid` in 1: back-buffer row write request.
- `wr_row` in 3: row index to write.
- `wr_data` in 8: pixel bits for that row; bit j = column j.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready`.
- `commit` in 1: one-cycle pulse requesting a buffer swap at the next frame boundary.
- `frame_done` out 1: one-cycle pulse in the cycle after a swap.
- `row` out 8: row select, active-low. Only one bit is low during the active window.
- `d` out 8: column data, active-high.

Behaviour:
- Reset, while `reset_n` = 0 at a clock edge:
  - `div`=0, `row_idx`=0, front = buffer A, pending=0.
  - Both buffers cleared to 0.
  - `row`=8'hFF, `d`=0, `wr_ready`=1, `frame_done`=0.
  - Reset mid-frame or mid-pending abandons the commit and the buffered data.
- Scan counters:
  - `div` counts 0..`SCAN_DIV`-1 and wraps.
  - When `div`=`SCAN_DIV`-1, `row_idx` increments, wrapping 7->0.
  - Frame boundary = (`div`=`SCAN_DIV`-1 && `row_idx`=7).
- Outputs are registered, one cycle of latency from the counter state:
  - `div` < `BLANK_CYCLES`: `row`=8'hFF, `d`=0.
  - Otherwise: `row`=~(8'b1 << `row_idx`), `d`=front[`row_idx`].
- Writes:
  - Target the back buffer only.
  - Accepted when `wr_valid && wr_ready`; the data is visible in the back buffer on the next cycle.
- Commit:
  - `commit` sets pending.
  - While pending=1, `wr_ready`=0.
  - A write in the same cycle as `commit` is still accepted, because `wr_ready` was 1 in that cycle.
  - A `commit` while already pending is ignored.
- Swap:
  - At a frame boundary with (pending || `commit`), front/back exchange, pending clears and `frame_done` pulses the next cycle.
  - A `commit` arriving exactly on the boundary cycle swaps immediately; it is not deferred a frame.
  - The first row scanned after a swap is row 0 from the new front.
  - After the swap the back buffer holds the old front contents. Writers rewrite every row they intend to change.
- No swap ever occurs without a commit; the front image persists indefinitely.
- `wr_row` is a full 3-bit index, so no out-of-range rows exist.

Optional Feature:
- Macro `LED_MATRIX_PWM_EN`.
- When defined:
  - Adds input port `brightness` in 4.
  - A 4-bit `pwm_cnt` resets to 0 at the start of each active window and increments every active cycle, wrapping at 16.
  - `d` = front[`row_idx`] when `pwm_cnt` < `brightness`, else 0.
  - `brightness`=0 gives a dark display; `brightness`=15 gives 15/16 duty.
  - `row` timing is unchanged.
- When undefined: no `brightness` port, and `d` is driven for the whole active window.

Test Plan (`SCAN_DIV`=8, `BLANK_CYCLES`=2 unless stated):
1. Reset: hold `reset_n`=0 for 3 cycles, then release -> `row`=8'hFF and `d`=0 through the blanking window; then `row`=8'hFE and `d`=0 (empty front). `wr_ready`=1 and `frame_done`=0 throughout.
2. Write then commit:
   - Stimulus: write rows 0..7 with 8'h01<<r, then pulse `commit`.
   - Required: `wr_ready` drops to 0 the next cycle.
   - At the next frame boundary: `frame_done` pulses once.
   - Following frame: in each active window `row`=~(1<<r) and `d`=8'h01<<r.
   - `wr_ready` returns to 1.
3. Commit on the boundary:
   - Stimulus: assert `commit` exactly in the cycle `div`=7 with `row_idx`=7.
   - Required: swap in that same cycle; `frame_done` pulses on the next cycle; row 0 of the new front (8'hAA written beforehand) appears in the next active window.
4. No tearing:
   - Stimulus: with front showing 8'hFF on all rows, write 8'h00 to row 3 without a commit.
   - Required: over 3 full frames, row 3 still shows `d`=8'hFF; `wr_ready` stays 1.
5. Reset mid-pending:
   - Stimulus: pulse `commit`, then assert `reset_n`=0 at `row_idx`=4.
   - Required: after release, no `frame_done` ever occurs; `d`=0 on all rows; `wr_ready`=1.
6. PWM (with `LED_MATRIX_PWM_EN`, `SCAN_DIV`=40, `BLANK_CYCLES`=4):
   - `brightness`=4 and front row 0 = 8'hFF -> `d`=8'hFF for cycles 0-3 of every 16-cycle PWM period within the active window, 0 otherwise.
   - `brightness`=0 -> `d`=0 always.
